// File: rtl/fir_fold_param.sv
// Folded FIR filter: MULS multipliers are time-shared over C MAC cycles per sample.
// Runtime-writable coefficients. Define FIR_FOLD_SYM_EN for symmetric pre-add mode (TAPS even).
module fir_fold_param #(
  parameter int TAPS      = 6,
  parameter int MULS      = 2,
  parameter int DIN_W     = 5,
  parameter int COEF_W    = 8,
  parameter int DOUT_W    = 8,
  parameter int OUT_SHIFT = 0,
  parameter logic [TAPS*COEF_W-1:0] COEF_INIT = {TAPS{COEF_W'(1)}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIN_W-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [DOUT_W-1:0]        dout,
  output logic                     dout_valid,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     coef_ready
);

`ifdef FIR_FOLD_SYM_EN
  localparam int NTERM = TAPS / 2;
`else
  localparam int NTERM = TAPS;
`endif
  localparam int C     = (NTERM + MULS - 1) / MULS;
  localparam int ACC_W = DIN_W + COEF_W + $clog2(TAPS) + 1;
  localparam int PH_W  = (C > 1) ? $clog2(C) : 1;
  localparam int AW    = $clog2(TAPS);
  localparam int SW    = (ACC_W > DOUT_W) ? ACC_W : DOUT_W;

  typedef enum logic {IDLE, MAC} state_t;

  state_t            state, state_nxt;
  logic [DIN_W-1:0]  x    [TAPS];
  logic [COEF_W-1:0] coef [TAPS];
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  mac_sum;
  logic [PH_W-1:0]   phase;
  logic              accept;
  logic              coef_wr;
  logic              last;

  function automatic logic [DOUT_W-1:0] sat(input logic [ACC_W-1:0] v);
    logic [SW-1:0] s;
    s = SW'(v) >> OUT_SHIFT;
    if (s > SW'({DOUT_W{1'b1}}))
      return {DOUT_W{1'b1}};
    return s[DOUT_W-1:0];
  endfunction

  assign din_ready  = (state == IDLE);
  assign coef_ready = (state == IDLE);
  assign accept     = din_valid & din_ready;
  assign coef_wr    = coef_we & coef_ready & (int'(coef_addr) < NTERM);
  assign last       = (int'(phase) == C - 1);

  // One fold step: MULS products of the current phase added onto the accumulator.
  always_comb begin
    int               k;
    logic [AW-1:0]    ki;
    logic [DIN_W:0]   opv;
    mac_sum = acc;
    k       = 0;
    ki      = '0;
    opv     = '0;
    for (int j = 0; j < MULS; j++) begin
      k  = int'(phase) * MULS + j;
      ki = AW'(k);
      if (k < NTERM) begin
`ifdef FIR_FOLD_SYM_EN
        opv = {1'b0, x[ki]} + {1'b0, x[AW'(TAPS - 1 - k)]};
`else
        opv = {1'b0, x[ki]};
`endif
        mac_sum = mac_sum + ACC_W'(coef[ki]) * ACC_W'(opv);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: delay line, coefficient bank, accumulator and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      phase      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x[i]    <= '0;
        coef[i] <= COEF_INIT[i*COEF_W +: COEF_W];
      end
    end else begin
      dout_valid <= 1'b0;
      if (coef_wr)
        coef[coef_addr] <= coef_data;
      if (state == IDLE) begin
        if (accept) begin
          x[0] <= din;
          for (int i = 1; i < TAPS; i++)
            x[i] <= x[i-1];
          acc   <= '0;
          phase <= '0;
        end
      end else begin
        if (last) begin
          dout       <= sat(mac_sum);
          dout_valid <= 1'b1;
        end else begin
          acc   <= mac_sum;
          phase <= phase + PH_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_fold_param.sv
// Scoreboard bench for fir_fold_param (default parameters; FIR_FOLD_SYM_EN changes latency
// and the scenario-3 tail value).
module tb_fir_fold_param;

`ifdef FIR_FOLD_SYM_EN
  localparam int C_LAT = 2;
  localparam int S3_LAST = 6;
`else
  localparam int C_LAT = 3;
  localparam int S3_LAST = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       coef_we = 1'b0;
  logic [2:0] coef_addr = '0;
  logic [7:0] coef_data = '0;
  logic       coef_ready;

  typedef struct {int val; int cyc;} exp_t;
  exp_t sb[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int last_acc = 0;

  int exp1[7] = '{1, 3, 6, 10, 15, 21, 27};
  int exp2[6] = '{62, 124, 186, 248, 255, 255};

  fir_fold_param dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_ready(coef_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (dout_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_dout_valid: got dout=%0d, expected no output", dout);
        end else begin
          e = sb.pop_front();
          check("dout", int'(dout), e.val);
          check("dout_valid_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic send(input int d, input int ev, input bit push);
    int w;
    @(negedge clk);
    din       = 5'(d);
    din_valid = 1'b1;
    w = 0;
    while (!din_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!din_ready) check("send_timeout", 0, 1);
    last_acc = cyc + 1;
    if (push) sb.push_back('{ev, cyc + 1 + C_LAT});
  endtask

  task automatic stop_stream();
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wcoef(input int a, input int d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = 8'(d);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int prev;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_dout", int'(dout), 0);
    check("reset_dout_valid", int'(dout_valid), 0);
    check("reset_din_ready", int'(din_ready), 1);
    check("reset_coef_ready", int'(coef_ready), 1);

    // Scenario 1: unit coefficients, back-to-back stream.
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      send(i + 1, exp1[i], 1'b1);
      if (i > 0) check("accept_spacing", last_acc - prev, C_LAT + 1);
      prev = last_acc;
    end
    stop_stream();
    drain();

    // Scenario 2: saturation with coefficients of 2.
    do_reset();
    for (int a = 0; a < 6; a++) wcoef(a, 2);
    for (int i = 0; i < 6; i++) send(31, exp2[i], 1'b1);
    stop_stream();
    drain();

    // Scenario 3: per-tap coefficient writes.
    do_reset();
    wcoef(0, 3);
    wcoef(5, 0);
    send(2, 6, 1'b1);
    for (int i = 0; i < 4; i++) send(0, 2, 1'b1);
    send(0, S3_LAST, 1'b1);
    stop_stream();
    drain();

    // Scenario 4: write during MAC is dropped.
    do_reset();
    send(1, 1, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 8'd9;
    check("coef_ready_in_mac", int'(coef_ready), 0);
    check("din_ready_in_mac", int'(din_ready), 0);
    @(negedge clk);
    coef_we = 1'b0;
    send(2, 3, 1'b1);
    send(3, 6, 1'b1);
    stop_stream();
    drain();

    // Scenario 5: reset one cycle after an accept aborts the sample.
    send(7, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    check("abort_dout", int'(dout), 0);
    check("abort_din_ready", int'(din_ready), 1);
    check("abort_dout_valid", int'(dout_valid), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    send(4, 4, 1'b1);
    stop_stream();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_fold_param.md
Name: fir_fold_param

Overview:
Parametrised, time-multiplexed (folded) FIR filter. It generalises the fixed 6-tap direct and folded FIR blocks to any tap count, multiplier count, data width and coefficient width. Coefficients are runtime-writable, the input uses a valid/ready handshake, and the output is saturated. It sits in the same sample path as the fixed FIR blocks and is checked against them in the shared simulation bench.

Parameters:
TAPS, 6, number of filter taps (>=2)
MULS, 2, multipliers used per cycle (1..TAPS)
DIN_W, 5, unsigned input sample width
COEF_W, 8, unsigned coefficient width
DOUT_W, 8, unsigned output width
OUT_SHIFT, 0, right shift applied to the accumulator before saturation
COEF_INIT, each coefficient = 1, packed TAPS*COEF_W reset value; coefficient k is at bits [k*COEF_W +: COEF_W]

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
din  in  DIN_W  input sample
din_valid  in  1  input sample valid
din_ready  out  1  block can accept a sample
dout  out  DOUT_W  filtered output
dout_valid  out  1  one-cycle pulse when dout is updated
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  coefficient index
coef_data  in  COEF_W  coefficient value
coef_ready  out  1  coefficient write will be honoured this cycle

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: dout=0, dout_valid=0, din_ready=1, coef_ready=1. Delay line is all 0, accumulator is 0, coefficients = COEF_INIT, state=IDLE.
- C = ceil(TAPS/MULS) is the number of MAC cycles per sample.
- Accumulator width is ACC_W = DIN_W+COEF_W+clog2(TAPS)+1. No accumulator overflow is possible.
- States: IDLE and MAC.
  - din_ready = coef_ready = (state==IDLE).
- Accept: happens on an edge where din_valid & din_ready.
  - The delay line shifts; x[0] <= din.
  - Accumulator clears; phase counter <= 0; state goes to MAC.
  - A din_valid while din_ready=0 is not consumed. The source must hold din.
- MAC phase p (0..C-1), one edge each:
  - acc += sum over j of coef[p*MULS+j] * x[p*MULS+j], for each index < TAPS.
  - Indices >= TAPS contribute 0.
- Last MAC edge (p=C-1):
  - dout <= min((acc_final >> OUT_SHIFT), 2^DOUT_W-1).
  - dout_valid <= 1; state <= IDLE.
- dout_valid is high for exactly one cycle. It rises C edges after the accept edge.
- dout holds its value until the next update.
- Maximum throughput is one sample per C+1 cycles.
- Coefficient write: coef[coef_addr] <= coef_data on an edge where coef_we & coef_ready.
  - Writes with coef_addr >= TAPS are ignored.
  - A write while coef_ready=0 is dropped silently.
  - A write on the same edge as an accept is applied, and the new value is used for that sample.
- rst asserted mid-MAC:
  - The computation is aborted immediately; all state returns to reset values, including the coefficients.
  - No dout_valid is produced for the aborted sample.

Optional Feature:
FIR_FOLD_SYM_EN. Symmetric-coefficient mode; requires TAPS even.
- With the macro:
  - Each MAC step pre-adds (x[k]+x[TAPS-1-k]) and multiplies by coef[k], for k < TAPS/2.
  - C = ceil((TAPS/2)/MULS).
  - Writes with coef_addr >= TAPS/2 are ignored; coefficients TAPS/2..TAPS-1 are unused.
- Without the macro: full asymmetric behaviour as above. No pre-adder is instantiated.

Test Plan:
1. Defaults, coefficients all 1, stream din=1,2,3,4,5,6,7 with din_valid held high.
   -> dout = 1,3,6,10,15,21,27.
   -> each dout_valid 3 edges after its accept; accepts spaced 4 cycles apart.
2. Saturation: write all coefficients = 2, then feed din=31 six times.
   -> final dout=255 (the raw 372 is clamped); earlier outputs are 62,124,186,248,255.
3. Coefficient write: after reset, in IDLE write addr0=3 and addr5=0, then feed din=2 followed by zeros.
   -> first dout=6. The sample sits at x[5] on the 6th accept (the 5th zero after the 2), where it contributes 0, so that dout=0.
4. Dropped write: assert coef_we addr0=9 while state=MAC.
   -> coef_ready=0, the write is ignored, and the next outputs are unchanged from scenario 1's coefficients.
5. Reset mid-operation: assert rst one cycle after an accept.
   -> dout=0, dout_valid never pulses, din_ready=1.
   -> a subsequent din=4 gives dout=4.
6. FIR_FOLD_SYM_EN defined, TAPS=6, MULS=2, coefficients all 1, stream 1..6.
   -> dout = 1,3,6,10,15,21, each dout_valid 2 edges after its accept.
